// File: rtl/seg7_pkg.sv
// Shared definitions for the seg7 scan controller: nibble width, scanner
// state encoding and digit-enable polarity helpers.
package seg7_pkg;

   localparam int NIB_W = 4;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } scan_state_t;

   // Level that turns a digit off / on for the given enable polarity.
   function automatic logic dig_off(input logic act_low);
      return act_low;
   endfunction

   function automatic logic dig_on(input logic act_low);
      return ~act_low;
   endfunction

endpackage

// File: rtl/seg7_lzs.sv
// Leading-zero suppression mask: bit i set means digit i must stay dark.
// Digit 0 is never suppressed; a dp request ends the zero run at that digit.
module seg7_lzs
   import seg7_pkg::*;
#(
   parameter int NDIG = 4
) (
   input  logic [NDIG*NIB_W-1:0] nibs,
   input  logic [NDIG-1:0]       dp,
   input  logic                  lzs,
   output logic [NDIG-1:0]       sup
);

   logic [NDIG-1:0][NIB_W-1:0] nib_a;
   logic [NDIG-1:0]            zrun;

   assign nib_a = nibs;

   // zrun[i]: every digit from i up to the top is a blank zero without dp.
   always_comb begin
      logic run;
      run  = lzs;
      zrun = '0;
      for (int i = NDIG - 1; i >= 0; i--) begin
         run     = run & (nib_a[i] == '0) & ~dp[i];
         zrun[i] = run;
      end
   end

   assign sup = zrun & {{(NDIG-1){1'b1}}, 1'b0};

endmodule

// File: rtl/seg7_scan.sv
// Time-multiplexed 7-segment scan controller with dead-time, frame snapshots,
// per-digit blanking and leading-zero suppression. All outputs registered.
module seg7_scan
   import seg7_pkg::*;
#(
   parameter int NDIG        = 4,
   parameter int DIV         = 1000,
   parameter int DEAD        = 2,
   parameter int DIG_ACT_LOW = 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      en,
   input  logic [NDIG*4-1:0]         data,
   input  logic [NDIG-1:0]           dp_in,
   input  logic [NDIG-1:0]           blank,
   input  logic                      lzs,
   output logic [3:0]                nib_out,
   output logic                      dp_out,
   output logic [NDIG-1:0]           dig_en,
   output logic [$clog2(NDIG)-1:0]   digit_idx,
   output logic                      frame_tick
);

   localparam int IW = $clog2(NDIG);
   localparam int CW = $clog2(DIV);
   localparam logic [CW-1:0] CNT_MAX  = CW'(DIV - 1);
   localparam logic [CW-1:0] CNT_DEAD = CW'(DEAD);
   localparam logic [IW-1:0] IDX_MAX  = IW'(NDIG - 1);
   localparam logic          ACT_LOW  = (DIG_ACT_LOW != 0);

   scan_state_t state, nxt_state;
   logic [CW-1:0] cnt, nxt_cnt;
   logic [IW-1:0] nxt_idx;
   logic          take_snap;

   logic [NDIG*NIB_W-1:0] snap_data, snap_data_nxt;
   logic [NDIG-1:0]       snap_dp, snap_dp_nxt;
   logic [NDIG-1:0]       snap_blank, snap_blank_nxt;
   logic                  snap_lzs, snap_lzs_nxt;

   logic [NDIG-1:0][NIB_W-1:0] nibs_nxt;
   logic [NDIG-1:0]            sup_nxt;
   logic [NDIG-1:0]            lit_nxt;
   logic [NDIG-1:0]            onehot_nxt;
   logic [NDIG-1:0]            dig_nxt;
   logic                       dig_on_nxt;

   // Next-state: slot prescaler, digit index and snapshot strobe.
   always_comb begin
      nxt_state = state;
      nxt_cnt   = cnt;
      nxt_idx   = digit_idx;
      take_snap = 1'b0;
      case (state)
         IDLE: begin
            nxt_cnt = '0;
            nxt_idx = '0;
            if (en) begin
               nxt_state = RUN;
               take_snap = 1'b1;
            end
         end
         RUN: begin
            if (!en) begin
               nxt_state = IDLE;
               nxt_cnt   = '0;
               nxt_idx   = '0;
            end else if (cnt == CNT_MAX) begin
               nxt_cnt = '0;
               if (digit_idx == IDX_MAX) begin
                  nxt_idx   = '0;
                  take_snap = 1'b1;
               end else begin
                  nxt_idx = digit_idx + 1'b1;
               end
            end else begin
               nxt_cnt = cnt + 1'b1;
            end
         end
         default: begin
            nxt_state = IDLE;
            nxt_cnt   = '0;
            nxt_idx   = '0;
         end
      endcase
   end

   // Outputs are computed from the snapshot that will be in force next cycle,
   // so the first slot of a new frame already reflects the fresh capture.
   assign snap_data_nxt  = take_snap ? data  : snap_data;
   assign snap_dp_nxt    = take_snap ? dp_in : snap_dp;
   assign snap_blank_nxt = take_snap ? blank : snap_blank;
   assign snap_lzs_nxt   = take_snap ? lzs   : snap_lzs;
   assign nibs_nxt       = snap_data_nxt;

   seg7_lzs #(
      .NDIG (NDIG)
   ) u_lzs (
      .nibs (snap_data_nxt),
      .dp   (snap_dp_nxt),
      .lzs  (snap_lzs_nxt),
      .sup  (sup_nxt)
   );

   assign lit_nxt    = ~snap_blank_nxt & ~sup_nxt;
   assign onehot_nxt = {{(NDIG-1){1'b0}}, 1'b1} << nxt_idx;
   assign dig_on_nxt = (nxt_state == RUN) && (nxt_cnt >= CNT_DEAD) && lit_nxt[nxt_idx];

   always_comb begin
      dig_nxt = '0;
      for (int i = 0; i < NDIG; i++) begin
         dig_nxt[i] = (dig_on_nxt && onehot_nxt[i]) ? dig_on(ACT_LOW) : dig_off(ACT_LOW);
      end
   end

   // Registered state, snapshot and display outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         digit_idx  <= '0;
         snap_data  <= '0;
         snap_dp    <= '0;
         snap_blank <= '0;
         snap_lzs   <= 1'b0;
         nib_out    <= '0;
         dp_out     <= 1'b0;
         frame_tick <= 1'b0;
         dig_en     <= {NDIG{dig_off(ACT_LOW)}};
      end else begin
         state      <= nxt_state;
         cnt        <= nxt_cnt;
         digit_idx  <= nxt_idx;
         snap_data  <= snap_data_nxt;
         snap_dp    <= snap_dp_nxt;
         snap_blank <= snap_blank_nxt;
         snap_lzs   <= snap_lzs_nxt;
         frame_tick <= take_snap;
         dig_en     <= dig_nxt;
         if (nxt_state == RUN) begin
            nib_out <= nibs_nxt[nxt_idx];
            dp_out  <= snap_dp_nxt[nxt_idx];
         end else begin
            nib_out <= '0;
            dp_out  <= 1'b0;
         end
      end
   end

endmodule
